// File: rtl/router_pkg.sv
// Shared router types: cardinal directions, tile coordinates, tile transactions and the
// dimension-ordered (X then Y) route function.
package router_pkg;

   typedef enum logic [2:0] {
      NORTH = 3'd0,
      EAST  = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      LOCAL = 3'd4
   } t_cardinal;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
   } t_tile_id;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] data;
   } t_tile_trans;

   localparam int unsigned NumDirs = 5;

   // X is resolved fully before Y; equal coordinates terminate locally.
   function automatic t_cardinal xy_route(input t_tile_id dst, input t_tile_id own);
      if (dst.x > own.x) return EAST;
      if (dst.x < own.x) return WEST;
      if (dst.y > own.y) return NORTH;
      if (dst.y < own.y) return SOUTH;
      return LOCAL;
   endfunction

endpackage

// File: rtl/router_in_dispatch_fifo.sv
// Small circular queue with registered, reset storage; the head is read straight from the
// storage array, so no input reaches rdata_o within a cycle.
module router_in_dispatch_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [CntW-1:0] DepthC = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         cnt_q <= cnt_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == DepthC);
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/router_in_dispatch.sv
// Input-side dispatcher: queues incoming transactions with their XY route, presents the head
// to exactly one direction, drops U-turns with a pulse, and watches for a stalled head.
module router_in_dispatch
   import router_pkg::*;
#(
   parameter t_cardinal   PortDir    = LOCAL,
   parameter int unsigned BufDepth   = 2,
   parameter int unsigned StallLimit = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  t_tile_id             local_tile_id_i,
   input  logic                 in_req_valid_i,
   input  t_tile_trans          in_req_i,
   output logic                 in_ready_o,
   output t_tile_trans          out_req_o,
   output logic [NumDirs-1:0]   out_valid_o,
   input  logic [NumDirs-1:0]   out_ready_i,
   output logic                 err_uturn_o,
   output logic                 stall_alarm_o
);

   typedef struct packed {
      t_cardinal   route;
      t_tile_trans trans;
   } t_entry;

   localparam int unsigned EntryW  = $bits(t_tile_trans) + 3;
   localparam logic [15:0] StallLim = 16'(StallLimit);

   t_entry      wr_entry, head_entry;
   logic        push, pop, full, empty, head_valid, uturn;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        stall_alarm_q;

   assign wr_entry.route = xy_route(t_tile_id'(in_req_i.address[31:24]), local_tile_id_i);
   assign wr_entry.trans = in_req_i;

   assign in_ready_o = !full;
   assign push       = in_req_valid_i && in_ready_o;
   assign head_valid = !empty;

   // An entry routed back out of the port it arrived on is discarded at the head.
   assign uturn = head_valid && (PortDir != LOCAL) && (head_entry.route == PortDir);
   assign pop   = head_valid && (uturn || out_ready_i[head_entry.route]);

   router_in_dispatch_fifo #(
      .Width (EntryW),
      .Depth (BufDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (head_entry),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      out_valid_o = '0;
      if (head_valid && !uturn) out_valid_o[head_entry.route] = 1'b1;
   end

   assign out_req_o   = head_entry.trans;
   assign err_uturn_o = uturn;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!head_valid || pop)          stall_cnt_d = '0;
      else if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q   <= '0;
         stall_alarm_q <= 1'b0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         stall_alarm_q <= stall_alarm_q | (stall_cnt_d >= StallLim);
      end
   end

   assign stall_alarm_o = stall_alarm_q;

endmodule

// File: tb/tb_router_in_dispatch.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_router_in_dispatch;
   import router_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
   localparam int PORT  = 3;  // WEST

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   t_tile_id          local_id;
   logic              in_req_valid = 1'b0;
   t_tile_trans       in_req = '0;
   logic              in_ready;
   t_tile_trans       out_req;
   logic [4:0]        out_valid;
   logic [4:0]        out_ready = '0;
   logic              err_uturn;
   logic              stall_alarm;

   router_in_dispatch #(
      .PortDir    (WEST),
      .BufDepth   (DEPTH),
      .StallLimit (LIMIT)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .local_tile_id_i (local_id),
      .in_req_valid_i  (in_req_valid),
      .in_req_i        (in_req),
      .in_ready_o      (in_ready),
      .out_req_o       (out_req),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .err_uturn_o     (err_uturn),
      .stall_alarm_o   (stall_alarm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          dir;
   } m_ent;

   m_ent mq[$];
   int   m_cnt = 0;
   bit   m_alarm = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   dut_pops = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Direction numbers: N=0 E=1 S=2 W=3 L=4.
   function automatic int model_route(input logic [31:0] addr, input logic [7:0] lid);
      int tx = int'(addr[31:28]);
      int ty = int'(addr[27:24]);
      int lx = int'(lid[7:4]);
      int ly = int'(lid[3:0]);
      if (tx > lx) return 1;
      if (tx < lx) return 3;
      if (ty > ly) return 0;
      if (ty < ly) return 2;
      return 4;
   endfunction

   task automatic check_outputs();
      logic [4:0] ev = '0;
      bit         eu = 0;
      if (mq.size() > 0) begin
         if (mq[0].dir == PORT) eu = 1;
         else ev = 5'(1 << mq[0].dir);
      end
      check("out_valid", 64'(out_valid), 64'(ev));
      check("err_uturn", 64'(err_uturn), 64'(eu));
      check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      check("stall_alarm", 64'(stall_alarm), 64'(m_alarm));
      if (mq.size() > 0) check("out_req", 64'(out_req), {mq[0].a, mq[0].d});
   endtask

   task automatic model_advance();
      bit   push = in_req_valid && (mq.size() < DEPTH);
      bit   popm = 0;
      m_ent e;
      if (mq.size() > 0) popm = (mq[0].dir == PORT) || out_ready[mq[0].dir];
      if (mq.size() > 0 && !popm) m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      else m_cnt = 0;
      if (m_cnt >= LIMIT) m_alarm = 1;
      if (popm) mq.delete(0);
      if (push) begin
         e.a = in_req.address;
         e.d = in_req.data;
         e.dir = model_route(in_req.address, 8'h22);
         mq.push_back(e);
      end
   endtask

   task automatic step(input bit v, input logic [31:0] a, input logic [4:0] rdy);
      @(negedge clk);
      in_req_valid   = v;
      in_req.address = a;
      in_req.data    = $urandom;
      out_ready      = rdy;
      check_outputs();
      if ((out_valid & out_ready) != 0) dut_pops++;
      model_advance();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      in_req_valid = 1'b1;
      #1;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd1);
      check("rst out_req", 64'(out_req), 64'd0);
      check("rst stall_alarm", 64'(stall_alarm), 64'd0);
      check("rst err_uturn", 64'(err_uturn), 64'd0);
      @(posedge clk);
      @(negedge clk);
      in_req_valid = 1'b0;
      check("rst hold in_ready", 64'(in_ready), 64'd1);
      check("rst hold out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      mq.delete();
      m_cnt   = 0;
      m_alarm = 0;
   endtask

   initial begin
      local_id = t_tile_id'(8'h22);
      do_reset();

      // Basic routes with every target ready.
      step(1, 32'h4500_0000, 5'b11111);
      step(1, 32'h2500_0000, 5'b11111);
      check("route east", 64'(out_valid), 64'h02);
      step(1, 32'h2200_0000, 5'b11111);
      check("route north", 64'(out_valid), 64'h01);
      step(0, 32'h0, 5'b11111);
      check("route local", 64'(out_valid), 64'h10);
      step(0, 32'h0, 5'b11111);

      // EAST blocked: third push refused, then in-order drain.
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 32'h4500_0000 | i, 5'b11101);
      check("full in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 4; i++) step(0, 32'h0, 5'b11111);

      // U-turn drop followed by the next entry one cycle later.
      do_reset();
      step(1, 32'h1000_0000, 5'b11111);
      step(1, 32'h4500_0000, 5'b11111);
      check("uturn pulse", 64'(err_uturn), 64'd1);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 5'b11111);

      // Stall watchdog: alarm after LIMIT blocked cycles, sticky after release.
      do_reset();
      step(1, 32'h2500_0000, 5'b11110);
      for (int i = 0; i < 6; i++) step(0, 32'h0, 5'b11110);
      check("stall set", 64'(stall_alarm), 64'd1);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 5'b11111);
      check("stall sticky", 64'(stall_alarm), 64'd1);

      // Reset with two entries queued.
      do_reset();
      step(1, 32'h2200_0001, 5'b00000);
      step(1, 32'h2200_0002, 5'b00000);
      step(0, 32'h0, 5'b00000);
      do_reset();
      step(0, 32'h0, 5'b11111);

      // Throughput from a full queue.
      step(1, 32'h2200_0010, 5'b00000);
      step(1, 32'h2200_0011, 5'b00000);
      dut_pops = 0;
      for (int i = 0; i < 20; i++) step(1, 32'h2200_0100 + i, 5'b11111);
      check("throughput pops", 64'(dut_pops), 64'd20);
      step(0, 32'h0, 5'b11111);
      step(0, 32'h0, 5'b11111);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [4:0] r;
         for (int b = 0; b < 5; b++) r[b] = ($urandom_range(0, 9) < 7);
         step(bit'($urandom_range(0, 1)), $urandom, r);
      end
      for (int i = 0; i < 4; i++) step(0, 32'h0, 5'b11111);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/router_in_dispatch.md
# router_in_dispatch

Input-side dispatcher of one router port; the producer end of the per-direction `fifo_arb` valid/ready alloc interface. It accepts tile transactions from one neighbour link (or the local core), buffers them in a 2-entry queue, and computes the XY route of the head entry. It then drives exactly one of five direction outputs (N/E/S/W/LOCAL) until the target arbiter FIFO accepts. A stall watchdog flags a head entry blocked for too long.

## Interface
- `PORT_DIR`, default `LOCAL`: `t_cardinal` direction this instance receives from; used for U-turn detection.
- `BUF_DEPTH`, default 2: input queue depth; legal values 2..8, power of two.
- `STALL_LIMIT`, default 255: head-blocked cycles before `stall_alarm` sets; 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low, synchronous deassert upstream.
- `local_tile_id` in `t_tile_id` (8): own tile coordinates {x[7:4], y[3:0]}; static after reset.
- `in_req_valid` in 1: incoming transaction valid.
- `in_req` in `t_tile_trans`: incoming transaction.
- `in_ready` out 1: queue not full.
- `out_req` out `t_tile_trans`: head entry, shared by all five outputs.
- `out_valid` out 5: one-hot or zero, indexed by `t_cardinal`; feeds `valid_alloc_reqN` of the targeted arbiter.
- `out_ready` in 5: `out_ready_fifoN` from each targeted arbiter.
- `err_uturn` out 1: one-cycle pulse when a U-turn entry is dropped.
- `stall_alarm` out 1: sticky; cleared by reset only.

## Operation
- Target tile = `in_req.address[31:24]`, split as tx = [31:28], ty = [27:24]; lx/ly come from `local_tile_id`.
- Route is dimension-ordered, X first:
  - tx>lx → EAST; tx<lx → WEST.
  - Else ty>ly → NORTH; ty<ly → SOUTH.
  - Else LOCAL.
  - Compares are unsigned 4-bit.
- Route is computed at push time and stored alongside the entry (3-bit `t_cardinal`), not recomputed at the head.
- Push when `in_req_valid && in_ready`. Pop when `out_valid[d] && out_ready[d]` for the stored route d.
- Routed direction == `PORT_DIR` and `PORT_DIR != LOCAL`: the entry is pushed but never presented. It is popped in the cycle it reaches the head, with `out_valid` = 0 and `err_uturn` = 1 for that cycle.
- Head valid entries hold `out_req`/`out_valid` stable until accepted. Head-of-line blocking is intended: no bypass of a stalled head.
- Watchdog:
  - 16-bit counter increments each cycle the head is valid and not popped; clears on pop or when the queue is empty.
  - Counter reaching `STALL_LIMIT` sets `stall_alarm`.
  - Counter saturates and does not wrap.

## Timing
- Reset values:
  - `out_valid` = 0, `err_uturn` = 0, `stall_alarm` = 0.
  - `out_req` = 0: head storage is reset.
  - `in_ready` = 1 (count = 0). Pushes while `rst` is low are discarded.
- Latency: entry pushed at edge N appears on `out_valid`/`out_req` after edge N, i.e. visible in cycle N+1. No combinational path from `in_req` to `out_*`.
- `in_ready` = !(count == `BUF_DEPTH`), from registered count only. It never depends on `out_ready`, so there is no ready-to-ready loop.
- Simultaneous push and pop when full: push is refused (`in_ready` = 0). Count is unchanged when empty or mid-level.
- Read and write pointers wrap modulo `BUF_DEPTH`.
- Back-to-back accepts sustain 1 transaction/cycle when the target is ready every cycle.
- Reset asserted mid-operation discards all queued entries immediately (asynchronous). Outputs take their reset values within the same cycle.

## Structure
- `router_pkg` additions:
  - `t_cardinal` enum {NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4}.
  - `t_tile_id`.
  - `function xy_route(t_tile_id dst, t_tile_id own)` returning `t_cardinal`.
- One natural sub-module: `fifo`, instantiated for the queue with data width `$bits(t_tile_trans)+3`. It carries the stored route. Its `full`/`empty` drive `in_ready` and head valid.
- Watchdog and U-turn logic live in the top module.

## Test plan
- Local id 0x22; push address 0x4500_0000 with all `out_ready` = 1 → `out_valid` = 5'b00010 (EAST) one cycle later; then 0x2500_0000 → NORTH; 0x2200_0000 → LOCAL (5'b10000).
- Hold `out_ready[EAST]` = 0, push 3 EAST entries → third push sees `in_ready` = 0. Release ready → entries drain in order, one per cycle, with data intact.
- `PORT_DIR` = WEST, local 0x22, push dest 0x1000_0000 → `err_uturn` pulses once, `out_valid` stays 0, and the next entry is presented the following cycle.
- `STALL_LIMIT` = 4, block NORTH → `stall_alarm` rises after 4 blocked cycles and stays high after release.
- Assert `rst` low with 2 entries queued → `out_valid` = 0 immediately. After release the queue is empty and `in_ready` = 1.
- Full queue, `out_ready` = 1 and `in_req_valid` = 1 held → steady 1/cycle throughput, no drops, count stable.
